rng_bit_packer: RTL and testbench
=================================

// Module: rng_bit_packer
// PURPOSE
//  Entropy front-end stage that feeds the RNG core's word path.
//  - Accepts a raw 1-bit entropy stream from the oscillator sampler.
//  - Optionally applies a von Neumann corrector.
//  - Packs the corrected bits into WIDTH-bit words and offers them on a valid/ready port.
//  - Runs a repetition-count health test and keeps overrun/drop statistics for the control registers.
// PARAMETERS
//  WIDTH      32  output word width in bits (>=2)
//  REP_LIMIT  32  consecutive identical raw bits that raise REP_FAIL (>=2)
//  CNT_W      16  width of the DROP_COUNT statistic
// PORTS
//  ACLK        in   1      clock, all logic on rising edge
//  ARESETN     in   1      reset, synchronous, active-low
//  ENABLE      in   1      1 = accept raw bits; 0 = ignore them and flush the partial word
//  DEBIAS      in   1      1 = von Neumann corrector on; 0 = raw bits pass through
//  RAW_BIT     in   1      raw entropy bit
//  RAW_VALID   in   1      RAW_BIT is valid this cycle (no back-pressure)
//  WORD_DATA   out  WIDTH  packed word; first emitted bit ends up in the MSB
//  WORD_VALID  out  1      WORD_DATA holds an unconsumed word
//  WORD_READY  in   1      consumer accepts; transfer when WORD_VALID && WORD_READY
//  STAT_CLEAR  in   1      clears OVERRUN, REP_FAIL and DROP_COUNT
//  OVERRUN     out  1      sticky: a completed word was dropped
//  REP_FAIL    out  1      sticky: repetition-count test failed
//  DROP_COUNT  out  CNT_W  number of dropped words, saturating at all-ones
// BEHAVIOUR
//  Reset (ARESETN=0 at a clock edge):
//  - All outputs go to 0.
//  - Shift register, bit counter and run counter are cleared; corrector FSM goes to IDLE.
//  - Takes effect on the next edge even in the middle of a word.
//  Raw accept: a bit is accepted when RAW_VALID && ENABLE.
//  Corrector FSM (DEBIAS=1):
//  - IDLE: an accepted bit is stored in the hold bit -> HELD.
//  - HELD: on the next accepted bit:
//    - if it differs from the held bit, emit the held bit (pair 01 -> 0, pair 10 -> 1);
//    - if it equals the held bit (00 or 11), emit nothing;
//    - in both cases -> IDLE.
//  - DEBIAS=0: every accepted bit is emitted in the same cycle and the FSM is forced to IDLE.
//  - DEBIAS may change only while ENABLE=0; any other change is undefined.
//  Packer:
//  - Each emitted bit shifts in: sreg <= {sreg[WIDTH-2:0], bit}.
//  - The bit counter runs 0..WIDTH-1 and wraps to 0 on the WIDTH-th emitted bit (word complete).
//  - Word complete with WORD_VALID=0, or with WORD_VALID && WORD_READY in the same cycle:
//    WORD_DATA <= completed word and WORD_VALID=1 on the next cycle.
//  - Latency: 1 cycle from the WIDTH-th bit to WORD_VALID.
//  - Word complete while WORD_VALID && !WORD_READY: the new word is dropped.
//    WORD_DATA keeps the old word, OVERRUN <= 1, DROP_COUNT <= DROP_COUNT+1 (saturating).
//  Output handshake:
//  - WORD_DATA and WORD_VALID are registered and stay stable while WORD_VALID && !WORD_READY.
//  - After a transfer, WORD_VALID falls unless a new word loads in the same cycle.
//  ENABLE=0:
//  - Raw bits are ignored; the bit counter clears to 0 and the FSM goes to IDLE (partial word lost).
//  - The run counter is not touched.
//  - The holding register is kept and can still be consumed.
//  Repetition test, on accepted raw bits before the corrector:
//  - run=1 on a bit that differs from the previous raw bit, or on the first bit after reset.
//  - Otherwise run=run+1, saturating at REP_LIMIT.
//  - REP_FAIL <= 1 in the cycle after run reaches REP_LIMIT.
//  - The test runs regardless of DEBIAS.
//  STAT_CLEAR: clears OVERRUN, REP_FAIL and DROP_COUNT. If a set or increment occurs in the
//  same cycle, the set/increment wins (flag=1, DROP_COUNT=1).
// TESTING
//  T1 DEBIAS=0, READY=1, 32 bits of 0xA5A5F00F, MSB first
//     -> WORD_DATA=0xA5A5F00F, VALID high 1 cycle after the 32nd bit.
//  T2 DEBIAS=1, raw pattern 01,10,00,11 repeated for 128 bits -> one word 0x55555555, OVERRUN=0.
//  T3 READY=0, 64 bits (DEBIAS=0)
//     -> first word held unchanged, OVERRUN=1, DROP_COUNT=1; READY=1 then transfers the first word.
//  T4 32nd bit arrives in the same cycle as a transfer -> no overrun, new word valid on the next cycle.
//  T5 32 consecutive raw 1s -> REP_FAIL=1.
//     31 ones then a 0 -> REP_FAIL stays 0.
//     STAT_CLEAR -> 0.
//  T6 ENABLE low after 10 bits, then high with 32 new bits -> word contains only the new bits.
//     ARESETN low mid-word -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/rng_bit_packer.sv
// rtl/rng_bit_packer.sv - entropy bit packer with von Neumann corrector and repetition health test
module rng_bit_packer #(
  parameter int WIDTH     = 32,
  parameter int REP_LIMIT = 32,
  parameter int CNT_W     = 16
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             ENABLE,
  input  logic             DEBIAS,
  input  logic             RAW_BIT,
  input  logic             RAW_VALID,
  output logic [WIDTH-1:0] WORD_DATA,
  output logic             WORD_VALID,
  input  logic             WORD_READY,
  input  logic             STAT_CLEAR,
  output logic             OVERRUN,
  output logic             REP_FAIL,
  output logic [CNT_W-1:0] DROP_COUNT
);

  localparam int BCNT_W = $clog2(WIDTH);
  localparam int RUN_W  = $clog2(REP_LIMIT + 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(WIDTH - 1);
  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(REP_LIMIT);

  typedef enum logic {ST_IDLE, ST_HELD} state_t;

  state_t             state_q, state_d;
  logic               hold_q, hold_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               ovr_q, ovr_d;
  logic               rep_q, rep_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               prev_q, prev_d;
  logic               seen_q, seen_d;

  logic               accept;
  logic               emit;
  logic               emit_bit;
  logic               word_done;
  logic               load;
  logic               drop;
  logic               rep_set;
  logic [WIDTH-1:0]   word_next;

  assign accept = RAW_VALID && ENABLE;

  // Corrector: pass-through when DEBIAS=0, otherwise von Neumann pairing.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    emit     = 1'b0;
    emit_bit = RAW_BIT;
    if (!DEBIAS) begin
      state_d = ST_IDLE;
      emit    = accept;
    end else if (!ENABLE) begin
      state_d = ST_IDLE;
    end else if (accept) begin
      case (state_q)
        ST_IDLE: begin
          hold_d  = RAW_BIT;
          state_d = ST_HELD;
        end
        ST_HELD: begin
          state_d = ST_IDLE;
          if (RAW_BIT != hold_q) begin
            emit     = 1'b1;
            emit_bit = hold_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign word_next = {sreg_q[WIDTH-2:0], emit_bit};
  assign word_done = emit && (bcnt_q == BCNT_LAST);
  assign load      = word_done && (!valid_q || WORD_READY);
  assign drop      = word_done && valid_q && !WORD_READY;

  always_comb begin
    sreg_d = sreg_q;
    bcnt_d = bcnt_q;
    if (!ENABLE) begin
      bcnt_d = '0;
    end else if (emit) begin
      sreg_d = word_next;
      bcnt_d = (bcnt_q == BCNT_LAST) ? '0 : bcnt_q + 1'b1;
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && WORD_READY) valid_d = 1'b0;
    if (load) begin
      data_d  = word_next;
      valid_d = 1'b1;
    end
  end

  // Repetition count looks at raw accepted bits, independent of the corrector.
  always_comb begin
    run_d   = run_q;
    prev_d  = prev_q;
    seen_d  = seen_q;
    rep_set = 1'b0;
    if (accept) begin
      prev_d = RAW_BIT;
      seen_d = 1'b1;
      if (!seen_q || (RAW_BIT != prev_q)) begin
        run_d = RUN_W'(1);
      end else if (run_q != RUN_MAX) begin
        run_d = run_q + 1'b1;
      end
      rep_set = (run_d == RUN_MAX);
    end
  end

  // Statistics: a set or increment in the same cycle as STAT_CLEAR wins.
  always_comb begin
    ovr_d  = STAT_CLEAR ? 1'b0 : ovr_q;
    rep_d  = STAT_CLEAR ? 1'b0 : rep_q;
    drop_d = STAT_CLEAR ? '0 : drop_q;
    if (drop) begin
      ovr_d = 1'b1;
      if (STAT_CLEAR) begin
        drop_d = CNT_W'(1);
      end else if (drop_q != {CNT_W{1'b1}}) begin
        drop_d = drop_q + 1'b1;
      end
    end
    if (rep_set) rep_d = 1'b1;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q <= ST_IDLE;
      hold_q  <= 1'b0;
      sreg_q  <= '0;
      bcnt_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      rep_q   <= 1'b0;
      drop_q  <= '0;
      run_q   <= '0;
      prev_q  <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      sreg_q  <= sreg_d;
      bcnt_q  <= bcnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      rep_q   <= rep_d;
      drop_q  <= drop_d;
      run_q   <= run_d;
      prev_q  <= prev_d;
      seen_q  <= seen_d;
    end
  end

  assign WORD_DATA  = data_q;
  assign WORD_VALID = valid_q;
  assign OVERRUN    = ovr_q;
  assign REP_FAIL   = rep_q;
  assign DROP_COUNT = drop_q;

endmodule

// File: tb/tb_rng_bit_packer.sv
// tb/tb_rng_bit_packer.sv - directed vector bench for rng_bit_packer
module tb_rng_bit_packer;

  logic        clk;
  logic        aresetn;
  logic        enable;
  logic        debias;
  logic        raw_bit;
  logic        raw_valid;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic        stat_clear;
  logic        overrun;
  logic        rep_fail;
  logic [15:0] drop_count;

  rng_bit_packer #(.WIDTH(32), .REP_LIMIT(32), .CNT_W(16)) dut (
    .ACLK       (clk),
    .ARESETN    (aresetn),
    .ENABLE     (enable),
    .DEBIAS     (debias),
    .RAW_BIT    (raw_bit),
    .RAW_VALID  (raw_valid),
    .WORD_DATA  (word_data),
    .WORD_VALID (word_valid),
    .WORD_READY (word_ready),
    .STAT_CLEAR (stat_clear),
    .OVERRUN    (overrun),
    .REP_FAIL   (rep_fail),
    .DROP_COUNT (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        deb;
    logic [63:0] raw;
    logic [31:0] expw;
  } vec_t;

  vec_t vecs [7];
  int   applied    = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    raw_bit   = b;
    raw_valid = 1'b1;
    tick();
    raw_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[31-i]);
  endtask

  task automatic set_mode(input logic d);
    enable = 1'b0;
    tick();
    debias = d;
    tick();
    enable = 1'b1;
  endtask

  task automatic clear_stats();
    stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b0, {32'hA5A5F00F, 32'h0}, 32'hA5A5F00F};
    vecs[1] = '{1'b0, {32'h12345678, 32'h0}, 32'h12345678};
    vecs[2] = '{1'b0, {32'h80000001, 32'h0}, 32'h80000001};
    vecs[3] = '{1'b0, {32'hFFFFFFFF, 32'h0}, 32'hFFFFFFFF};
    vecs[4] = '{1'b1, 64'hAA55AA55AA55AA55, 32'hF0F0F0F0};
    vecs[5] = '{1'b1, 64'h5555555555555556, 32'h00000001};
    vecs[6] = '{1'b1, 64'hAAAAAAAAAAAAAAAA, 32'hFFFFFFFF};

    aresetn = 1'b0; enable = 1'b0; debias = 1'b0; raw_bit = 1'b0;
    raw_valid = 1'b0; word_ready = 1'b0; stat_clear = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
    check("rst_valid", word_valid, 0);
    check("rst_data", word_data, 0);
    check("rst_overrun", overrun, 0);
    check("rst_rep_fail", rep_fail, 0);
    check("rst_drop", drop_count, 0);

    word_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      int n;
      set_mode(vecs[i].deb);
      n = vecs[i].deb ? 64 : 32;
      for (int k = 0; k < n - 1; k++) send_bit(vecs[i].raw[63-k]);
      check($sformatf("v%0d_pre_valid", i), word_valid, 0);
      send_bit(vecs[i].raw[63-(n-1)]);
      check($sformatf("v%0d_valid", i), word_valid, 1);
      check($sformatf("v%0d_data", i), word_data, vecs[i].expw);
      check($sformatf("v%0d_overrun", i), overrun, 0);
      tick();
      check($sformatf("v%0d_post_valid", i), word_valid, 0);
    end

    // debias with 01,10,00,11 groups
    clear_stats();
    word_ready = 1'b0;
    set_mode(1'b1);
    for (int g = 0; g < 16; g++) begin
      send_bit(0); send_bit(1); send_bit(1); send_bit(0);
      send_bit(0); send_bit(0); send_bit(1); send_bit(1);
    end
    check("t2_valid", word_valid, 1);
    check("t2_data", word_data, 32'h55555555);
    check("t2_overrun", overrun, 0);
    word_ready = 1'b1;
    tick();
    check("t2_consumed", word_valid, 0);

    // overrun with READY low, then clear colliding with a drop
    set_mode(1'b0);
    word_ready = 1'b0;
    clear_stats();
    send_word(32'h0F0F1234, 32);
    send_word(32'hCAFEBABE, 32);
    check("t3_data_held", word_data, 32'h0F0F1234);
    check("t3_valid", word_valid, 1);
    check("t3_overrun", overrun, 1);
    check("t3_drop", drop_count, 1);
    send_word(32'h13579BDF, 31);
    stat_clear = 1'b1;
    send_bit(1'b1);
    stat_clear = 1'b0;
    check("t3_clr_vs_inc_drop", drop_count, 1);
    check("t3_clr_vs_inc_ovr", overrun, 1);
    clear_stats();
    check("t3_clr_drop", drop_count, 0);
    check("t3_clr_ovr", overrun, 0);
    word_ready = 1'b1;
    check("t3_xfer_data", word_data, 32'h0F0F1234);
    tick();
    check("t3_xfer_valid", word_valid, 0);

    // word completes in the same cycle as a transfer
    word_ready = 1'b0;
    send_word(32'h11112222, 32);
    check("t4_first_valid", word_valid, 1);
    send_word(32'h89ABCDEF, 31);
    word_ready = 1'b1;
    send_bit(1'b1);
    check("t4_valid", word_valid, 1);
    check("t4_data", word_data, 32'h89ABCDEF);
    check("t4_overrun", overrun, 0);
    tick();
    check("t4_post_valid", word_valid, 0);

    // repetition count
    send_bit(1'b0);
    clear_stats();
    for (int i = 0; i < 31; i++) send_bit(1'b1);
    send_bit(1'b0);
    tick();
    check("t5_rep_31", rep_fail, 0);
    for (int i = 0; i < 32; i++) send_bit(1'b1);
    tick();
    check("t5_rep_32", rep_fail, 1);
    clear_stats();
    check("t5_rep_clr", rep_fail, 0);

    // ENABLE low drops the partial word
    set_mode(1'b0);
    word_ready = 1'b1;
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    enable = 1'b0;
    raw_bit = 1'b1;
    raw_valid = 1'b1;
    tick();
    tick();
    check("t6_dis_valid", word_valid, 0);
    raw_valid = 1'b0;
    enable = 1'b1;
    send_word(32'h3C3C5AA5, 32);
    check("t6_valid", word_valid, 1);
    check("t6_data", word_data, 32'h3C3C5AA5);
    tick();

    // reset in the middle of a word
    word_ready = 1'b0;
    clear_stats();
    for (int i = 0; i < 64; i++) send_bit(1'b1);
    check("t6_pre_ovr", overrun, 1);
    check("t6_pre_rep", rep_fail, 1);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    aresetn = 1'b0;
    raw_valid = 1'b1;
    tick();
    check("t6_rst_valid", word_valid, 0);
    check("t6_rst_data", word_data, 0);
    check("t6_rst_ovr", overrun, 0);
    check("t6_rst_rep", rep_fail, 0);
    check("t6_rst_drop", drop_count, 0);
    aresetn = 1'b1;
    raw_valid = 1'b0;
    send_word(32'h600DF00D, 32);
    check("t6_after_rst_valid", word_valid, 1);
    check("t6_after_rst_data", word_data, 32'h600DF00D);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
